// File: rtl/move_sequencer.sv
// move_sequencer: debounced one-move-per-press sequencer for move, spawn and redraw handshakes.
// Optional MSEQ_NOCHANGE_SKIP_EN: a move that changes no box skips spawn and redraw.
module move_sequencer #(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] key_n,
  input  logic       game_over,
  input  logic       move_ack,
  input  logic       move_done,
  input  logic       board_changed,
  input  logic       spawn_done,
  input  logic       draw_done,
  output logic       move_req,
  output logic [3:0] move_dir,
  output logic       spawn_req,
  output logic [3:0] spawn_cell,
  output logic       draw_req,
  output logic       busy,
  output logic [3:0] last_dir,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE, MREQ, MWAIT, SPAWN, DRAW, REL} st_t;
  localparam logic [CNT_W-1:0] DEB    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_M1 = CNT_W'(DEBOUNCE_CYCLES - 1);
  st_t              st;
  logic [3:0]       s1, raw, cand, keys, sel;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       lfsr;
  assign state = st;
  always_comb
    sel = keys[3] ? 4'b1000 : keys[2] ? 4'b0100 : keys[1] ? 4'b0010 : keys[0] ? 4'b0001 : 4'b0000;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      s1   <= '0;
      raw  <= '0;
      cand <= '0;
      keys <= '0;
      cnt  <= '0;
      lfsr <= 8'hA5;
    end else begin
      s1   <= ~key_n;
      raw  <= s1;
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (raw != cand) begin
        cand <= raw;
        cnt  <= '0;
      end else begin
        cnt <= (cnt == DEB) ? cnt : cnt + 1'b1;
        if (cnt == DEB_M1) keys <= cand;
      end
    end
`ifndef MSEQ_NOCHANGE_SKIP_EN
  logic unused_board_changed;
  assign unused_board_changed = board_changed;
`endif
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      st         <= IDLE;
      move_req   <= 1'b0;
      move_dir   <= '0;
      spawn_req  <= 1'b0;
      spawn_cell <= 4'h5;
      draw_req   <= 1'b0;
      busy       <= 1'b0;
      last_dir   <= '0;
    end else begin
      case (st)
        IDLE: if (keys != 4'b0 && !game_over) begin
          st       <= MREQ;
          move_req <= 1'b1;
          move_dir <= sel;
          last_dir <= sel;
          busy     <= 1'b1;
        end
        MREQ: if (move_ack) begin
          st       <= MWAIT;
          move_req <= 1'b0;
        end
        MWAIT: if (move_done) begin
`ifdef MSEQ_NOCHANGE_SKIP_EN
          if (!board_changed) st <= REL;
          else begin
            st         <= SPAWN;
            spawn_req  <= 1'b1;
            spawn_cell <= lfsr[3:0];
          end
`else
          st         <= SPAWN;
          spawn_req  <= 1'b1;
          spawn_cell <= lfsr[3:0];
`endif
        end
        SPAWN: if (spawn_done) begin
          st        <= DRAW;
          spawn_req <= 1'b0;
          draw_req  <= 1'b1;
        end
        DRAW: if (draw_done) begin
          st       <= REL;
          draw_req <= 1'b0;
        end
        REL: if (keys == 4'b0) begin
          st   <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          st        <= IDLE;
          move_req  <= 1'b0;
          spawn_req <= 1'b0;
          draw_req  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed bench for move_sequencer with a short debounce window.
module tb_move_sequencer;
  logic       clock = 1'b0, resetn = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic       game_over = 0, move_ack = 0, move_done = 0, board_changed = 0, spawn_done = 0, draw_done = 0;
  logic       move_req, spawn_req, draw_req, busy;
  logic [3:0] move_dir, spawn_cell, last_dir;
  logic [2:0] state;
  int n_chk = 0, n_err = 0;
  int req_cnt = 0, spawn_cnt = 0, draw_cnt = 0, cell_chg = 0;
  logic p_move = 0, p_spawn = 0, p_draw = 0;
  logic [3:0] p_cell = 0;
  move_sequencer #(.CNT_W(16), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .resetn(resetn), .key_n(key_n), .game_over(game_over),
    .move_ack(move_ack), .move_done(move_done), .board_changed(board_changed),
    .spawn_done(spawn_done), .draw_done(draw_done), .move_req(move_req),
    .move_dir(move_dir), .spawn_req(spawn_req), .spawn_cell(spawn_cell),
    .draw_req(draw_req), .busy(busy), .last_dir(last_dir), .state(state)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (move_req && !p_move) req_cnt++;
    if (spawn_req && !p_spawn) spawn_cnt++;
    if (draw_req && !p_draw) draw_cnt++;
    if (spawn_req && p_spawn && spawn_cell != p_cell) cell_chg++;
    p_move  = move_req;
    p_spawn = spawn_req;
    p_draw  = draw_req;
    p_cell  = spawn_cell;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic wait_req(input string tag);
    int i = 0;
    while (!move_req && i < 30) begin
      step(1);
      i++;
    end
    check(tag, 32'(move_req), 1);
  endtask
  task automatic wait_state(input string tag, input logic [2:0] exp);
    int i = 0;
    while (state != exp && i < 40) begin
      step(1);
      i++;
    end
    check(tag, 32'(state), 32'(exp));
  endtask
  // Each done/ack arrives two cycles after its request is seen.
  task automatic respond(input logic bc, input logic go);
    step(2); move_ack = 1; step(1); move_ack = 0;
    check("mwait", 32'(state), 2);
    check("move_req_fall", 32'(move_req), 0);
    if (go) game_over = 1;
    step(1); move_done = 1; board_changed = bc; step(1); move_done = 0; board_changed = 0;
`ifdef MSEQ_NOCHANGE_SKIP_EN
    if (!bc) begin
      check("skip_rel", 32'(state), 5);
      return;
    end
`endif
    check("spawn_state", 32'(state), 3);
    check("spawn_req", 32'(spawn_req), 1);
    step(2); spawn_done = 1; step(1); spawn_done = 0;
    check("draw_state", 32'(state), 4);
    check("draw_req", 32'(draw_req), 1);
    check("spawn_fall", 32'(spawn_req), 0);
    step(2); draw_done = 1; step(1); draw_done = 0;
    check("rel_state", 32'(state), 5);
    check("draw_fall", 32'(draw_req), 0);
  endtask
  initial begin
    logic seen;
    int s0;
    step(2);
    check("rst_state", 32'(state), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_move_req", 32'(move_req), 0);
    check("rst_cell", 32'(spawn_cell), 5);
    check("rst_last_dir", 32'(last_dir), 0);
    resetn = 1;
    step(2);
    // Stray move_done outside MWAIT does nothing.
    move_done = 1; step(1); move_done = 0; step(1);
    check("stray_done", 32'(state), 0);
    // Too-short press is filtered.
    key_n = 4'b1101; step(3); key_n = 4'hF;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (move_req || busy) seen = 1;
    end
    check("short_no_req", 32'(seen), 0);
    // Held press gives one left move.
    key_n = 4'b1101;
    wait_req("left_req");
    check("left_dir", 32'(move_dir), 32'h2);
    check("left_last", 32'(last_dir), 32'h2);
    check("left_state", 32'(state), 1);
    check("left_busy", 32'(busy), 1);
    step(3);
    key_n = 4'hF;
    respond(1, 0);
    wait_state("left_idle", 0);
    check("left_one_req", 32'(req_cnt), 1);
    check("left_one_spawn", 32'(spawn_cnt), 1);
    check("cell_stable", 32'(cell_chg), 0);
    // Up+right together: up wins; holding keeps REL.
    key_n = 4'b0110;
    wait_req("simul_req");
    check("simul_dir", 32'(move_dir), 32'h8);
    check("simul_last", 32'(last_dir), 32'h8);
    respond(1, 0);
    step(10);
    check("held_rel", 32'(state), 5);
    check("held_no_repeat", 32'(req_cnt), 2);
    key_n = 4'hF;
    wait_state("release_idle", 0);
    step(1);
    check("release_busy", 32'(busy), 0);
    // Game over blocks new presses.
    game_over = 1; key_n = 4'b0111;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (busy) seen = 1;
    end
    check("go_no_busy", 32'(seen), 0);
    key_n = 4'hF; step(15); game_over = 0;
    // Game over raised mid-sequence does not abort.
    key_n = 4'b1110;
    wait_req("right_req");
    check("right_dir", 32'(move_dir), 32'h1);
    key_n = 4'hF;
    respond(1, 1);
    wait_state("go_mid_idle", 0);
    game_over = 0;
    check("go_mid_spawns", 32'(spawn_cnt), 3);
    // No-change move.
    s0 = spawn_cnt;
    key_n = 4'b1011;
    wait_req("down_req");
    check("down_dir", 32'(move_dir), 32'h4);
    key_n = 4'hF;
    respond(0, 0);
    wait_state("nochg_idle", 0);
`ifdef MSEQ_NOCHANGE_SKIP_EN
    check("nochg_spawns", 32'(spawn_cnt - s0), 0);
    check("nochg_draws", 32'(draw_cnt), 3);
`else
    check("nochg_spawns", 32'(spawn_cnt - s0), 1);
    check("nochg_draws", 32'(draw_cnt), 4);
`endif
    // Asynchronous reset in DRAW.
    key_n = 4'b1101;
    wait_req("rst_seq_req");
    key_n = 4'hF;
    step(1); move_ack = 1; step(1); move_ack = 0; move_done = 1; board_changed = 1;
    step(1); move_done = 0; board_changed = 0; spawn_done = 1;
    step(1); spawn_done = 0;
    check("pre_rst_draw", 32'(state), 4);
    #2 resetn = 0;
    #1;
    check("async_state", 32'(state), 0);
    check("async_draw_req", 32'(draw_req), 0);
    check("async_busy", 32'(busy), 0);
    check("async_cell", 32'(spawn_cell), 5);
    check("async_dirs", 32'({move_dir, last_dir}), 0);
    step(2);
    resetn = 1;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
